pc_gen: RTL and testbench
=========================

Name: pc_gen

Overview:
- Parametrised next-generation PC unit for the TinyRISC-V fetch stage.
- Produces the instruction fetch address with a valid/ready handshake to instruction memory.
- Handles stall, prioritised trap/jump redirection, a post-reset boot delay and a debug halt/resume state machine.
- Sits between the execute/CSR redirect sources and the instruction memory address port.

Parameters:
- ADDR_WIDTH, 32, width of the PC and all address ports.
- RESET_ADDR, 32'h0000_0000, PC value loaded on reset; truncated to ADDR_WIDTH.
- BOOT_DELAY, 4, cycles spent in BOOT after reset before the first valid fetch; 0 is legal; range 0..255.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  synchronous reset, active-high.
- stall_i  input  1  pipeline stall; holds the PC.
- jump_en_i  input  1  branch/jump redirect request.
- jump_addr_i  input  ADDR_WIDTH  jump target.
- trap_en_i  input  1  trap/exception redirect request; highest priority.
- trap_addr_i  input  ADDR_WIDTH  trap vector.
- halt_req_i  input  1  debug halt request.
- resume_i  input  1  debug resume request.
- fetch_ready_i  input  1  instruction memory accepts the current address.
- pc_addr_o  output  ADDR_WIDTH  current fetch address.
- pc_valid_o  output  1  pc_addr_o is a valid fetch request.
- halted_o  output  1  block is in HALT.
- redirect_o  output  1  registered one-cycle pulse: a redirect was applied last edge.
- misalign_o  output  1  registered one-cycle pulse: the applied redirect target had non-zero alignment bits.

Behaviour:
- Reset (rst=1 at an edge):
  - state=BOOT; pc=RESET_ADDR; boot counter=0.
  - pc_valid_o=0, halted_o=0, redirect_o=0, misalign_o=0.
  - Reset asserted mid-operation overrides everything, including a pending redirect or HALT.
- States: BOOT, RUN, HALT. pc_valid_o=1 only in RUN.
- BOOT:
  - Counter increments each cycle; moves to RUN when counter==BOOT_DELAY-1.
  - BOOT_DELAY=0: RUN on the first cycle after reset release.
  - All redirects and halt_req_i are ignored; pc holds RESET_ADDR.
- RUN: next-PC priority, evaluated each edge:
  1. trap_en_i: pc=align(trap_addr_i).
  2. jump_en_i: pc=align(jump_addr_i).
  3. stall_i: hold.
  4. fetch_ready_i: pc=pc+4, wrapping modulo 2^ADDR_WIDTH.
  5. Otherwise hold.
- Redirects take effect regardless of stall_i or fetch_ready_i (a flush discards the outstanding request). Latency is one cycle: the target appears on pc_addr_o the cycle after the request.
- align() clears bits [1:0]. misalign_o pulses when the cleared bits of the winning target were non-zero. redirect_o pulses for any applied redirect.
- Handshake:
  - While pc_valid_o=1 and fetch_ready_i=0, pc_addr_o is stable unless a redirect occurs.
  - An address is accepted only when pc_valid_o & fetch_ready_i & !stall_i.
- RUN to HALT:
  - halt_req_i=1 moves to HALT at the next edge.
  - A simultaneous redirect is still applied, so the PC halts on the target.
  - A simultaneous fetch acceptance advances the PC; the PC halts on the next unfetched address.
- HALT:
  - pc_valid_o=0, halted_o=1.
  - jump_en_i updates pc (debug PC write) with redirect_o/misalign_o pulsing as normal; trap_en_i is ignored.
  - resume_i=1 with halt_req_i=0 moves to RUN at the next edge. If both are high, the block stays in HALT (halt wins).
- Wrap-around: pc = {ADDR_WIDTH{1'b1}} & ~3 increments to 0 with no flag.

Optional Feature:
- Macro: PC_COMPRESSED_EN
- Defined:
  - Adds input inst_len_i (1 bit: 0=16-bit, 1=32-bit, sampled at fetch acceptance).
  - Increment is 2 or 4 accordingly.
  - align() clears only bit 0; misalign_o checks bit 0 only.
- Undefined: inst_len_i is absent; increment fixed at 4; align() clears [1:0].

Decomposition:
- Shared defines.v additions:
  - PC state encodings `PC_ST_BOOT/`PC_ST_RUN/`PC_ST_HALT (2 bits).
  - `PC_STEP_WORD=4, `PC_STEP_HALF=2.
  - Reuse the existing `RV32_ADDR_WIDTH and `RST_INST_ADDR as the default sources for ADDR_WIDTH and RESET_ADDR.
- One sub-module: pc_redirect_sel. It is combinational: trap/jump priority, alignment mask and misalign detect. It outputs the selected target, a redirect-valid bit and a misalign bit. It is instantiated once in pc_gen.

Test Plan:
1. Reset with BOOT_DELAY=4, RESET_ADDR=0x100, fetch_ready_i=1 -> pc_valid_o=0 for 4 cycles after release, then 0x100, 0x104, 0x108 on consecutive cycles.
2. In RUN at pc=0x200, fetch_ready_i=0 for 3 cycles, then 1 -> pc_addr_o stays 0x200 while stalled, then 0x204.
3. jump_en_i=1 (0x403) and trap_en_i=1 (0x80) in the same cycle -> next pc=0x80, redirect_o=1, misalign_o=0. Next test: jump alone to 0x403 -> pc=0x400, misalign_o=1 for one cycle.
4. halt_req_i=1 with jump_en_i=1 (0x500) -> halted_o=1 and pc=0x500, pc_valid_o=0. Then jump 0x600 in HALT -> pc=0x600. Then trap in HALT -> ignored. Then resume_i and halt_req_i together -> stays HALT. Then resume_i alone -> RUN, valid fetch at 0x600.
5. pc=0xFFFF_FFFC, fetch accepted -> pc=0x0000_0000, no flags. Then rst=1 mid-run -> next cycle pc=RESET_ADDR, state BOOT, all outputs 0.
6. With PC_COMPRESSED_EN defined: pc=0x10, inst_len_i=0 accepted -> 0x12; inst_len_i=1 -> 0x16; jump to 0x21 -> pc=0x20, misalign_o=1.

Source files
------------

// File: rtl/pc_gen_pkg.sv
// pc_gen_pkg: shared types and constants for the fetch-stage PC generator.
// Optional build macro PC_COMPRESSED_EN selects halfword alignment
// (16/32-bit instructions) instead of word alignment.
package pc_gen_pkg;

   // FSM state encodings
   typedef enum logic [1:0] {
      PC_ST_BOOT = 2'd0,
      PC_ST_RUN  = 2'd1,
      PC_ST_HALT = 2'd2
   } pc_state_e;

   // PC increments for full and compressed instructions
   localparam int PC_STEP_WORD = 4;
   localparam int PC_STEP_HALF = 2;

   // Default address width and reset vector of the core
   localparam int          RV32_ADDR_WIDTH = 32;
   localparam logic [31:0] RST_INST_ADDR   = 32'h0000_0000;

   // Number of low address bits forced to zero on a redirect
`ifdef PC_COMPRESSED_EN
   localparam int PC_ALIGN_BITS = 1;
`else
   localparam int PC_ALIGN_BITS = 2;
`endif

endpackage

// File: rtl/pc_gen_if.sv
// pc_gen_if: fetch address handshake between the PC generator (master)
// and instruction memory (slave).
// With PC_COMPRESSED_EN defined, memory also returns the length of the
// instruction being accepted (0 = 16-bit, 1 = 32-bit).
interface pc_gen_if import pc_gen_pkg::*; #(
   parameter int ADDR_WIDTH = RV32_ADDR_WIDTH
);
   logic [ADDR_WIDTH-1:0] pc_addr_o;
   logic                  pc_valid_o;
   logic                  fetch_ready_i;
`ifdef PC_COMPRESSED_EN
   logic                  inst_len_i;

   modport master (output pc_addr_o, output pc_valid_o,
                   input  fetch_ready_i, input inst_len_i);
   modport slave  (input  pc_addr_o, input pc_valid_o,
                   output fetch_ready_i, output inst_len_i);
`else
   modport master (output pc_addr_o, output pc_valid_o,
                   input  fetch_ready_i);
   modport slave  (input  pc_addr_o, input pc_valid_o,
                   output fetch_ready_i);
`endif
endinterface

// File: rtl/pc_gen_redirect_sel.sv
// pc_redirect_sel: combinational redirect arbitration for pc_gen.
// Trap beats jump; the winning target has its alignment bits cleared and
// a misalign flag reports whether any of those bits were set.
// Alignment width follows PC_COMPRESSED_EN through pc_gen_pkg.
module pc_redirect_sel import pc_gen_pkg::*; #(
   parameter int ADDR_WIDTH = RV32_ADDR_WIDTH
) (
   input  logic                  trap_en_i,
   input  logic [ADDR_WIDTH-1:0] trap_addr_i,
   input  logic                  jump_en_i,
   input  logic [ADDR_WIDTH-1:0] jump_addr_i,
   output logic [ADDR_WIDTH-1:0] target_o,
   output logic                  redirect_o,
   output logic                  misalign_o
);

   localparam logic [ADDR_WIDTH-1:0] LOW_MASK = ADDR_WIDTH'((1 << PC_ALIGN_BITS) - 1);

   logic [ADDR_WIDTH-1:0] raw_target;

   // Pick the highest-priority request, then align it and flag dropped bits
   always_comb begin
      raw_target = trap_en_i ? trap_addr_i : jump_addr_i;
      target_o   = raw_target & ~LOW_MASK;
      redirect_o = trap_en_i | jump_en_i;
      misalign_o = (trap_en_i | jump_en_i) & ((raw_target & LOW_MASK) != '0);
   end

endmodule

// File: rtl/pc_gen.sv
// pc_gen: fetch-stage next-PC generator.
// BOOT waits BOOT_DELAY cycles after reset, RUN issues fetch addresses with
// trap > jump > stall > advance priority, HALT parks the PC for the debugger
// (jumps act as debug PC writes, traps are ignored).
// Optional build macro PC_COMPRESSED_EN enables 2-byte steps driven by the
// instruction length reported at fetch acceptance.
module pc_gen import pc_gen_pkg::*; #(
   parameter int          ADDR_WIDTH = RV32_ADDR_WIDTH,
   parameter logic [31:0] RESET_ADDR = RST_INST_ADDR,
   parameter int          BOOT_DELAY = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  stall_i,
   input  logic                  jump_en_i,
   input  logic [ADDR_WIDTH-1:0] jump_addr_i,
   input  logic                  trap_en_i,
   input  logic [ADDR_WIDTH-1:0] trap_addr_i,
   input  logic                  halt_req_i,
   input  logic                  resume_i,
   pc_gen_if.master              fetch_if,
   output logic                  halted_o,
   output logic                  redirect_o,
   output logic                  misalign_o
);

   localparam logic [ADDR_WIDTH-1:0] RST_PC = ADDR_WIDTH'(RESET_ADDR);

   pc_state_e             state_q;
   logic [ADDR_WIDTH-1:0] pc_q, pc_d;
   logic [7:0]            boot_cnt_q;
   logic                  valid_q, halted_q, redirect_q, misalign_q;

   logic                  sel_trap_en, sel_jump_en;
   logic [ADDR_WIDTH-1:0] sel_target;
   logic                  sel_redirect, sel_misalign;
   logic [ADDR_WIDTH-1:0] step;
   logic                  fetch_acc;
   logic                  boot_done;

   // Traps only matter while running; jumps also serve as debug PC writes in HALT
   assign sel_trap_en = trap_en_i & (state_q == PC_ST_RUN);
   assign sel_jump_en = jump_en_i & ((state_q == PC_ST_RUN) | (state_q == PC_ST_HALT));

   pc_redirect_sel #(
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_redirect_sel (
      .trap_en_i   (sel_trap_en),
      .trap_addr_i (trap_addr_i),
      .jump_en_i   (sel_jump_en),
      .jump_addr_i (jump_addr_i),
      .target_o    (sel_target),
      .redirect_o  (sel_redirect),
      .misalign_o  (sel_misalign)
   );

`ifdef PC_COMPRESSED_EN
   assign step = fetch_if.inst_len_i ? ADDR_WIDTH'(PC_STEP_WORD) : ADDR_WIDTH'(PC_STEP_HALF);
`else
   assign step = ADDR_WIDTH'(PC_STEP_WORD);
`endif

   // valid_q is only set in RUN, so this also implies the RUN state
   assign fetch_acc = valid_q & fetch_if.fetch_ready_i & ~stall_i;
   assign boot_done = (BOOT_DELAY == 0) || (boot_cnt_q == 8'(BOOT_DELAY - 1));

   // Next PC: redirect flushes any outstanding request, otherwise advance on acceptance
   always_comb begin
      pc_d = pc_q;
      if (sel_redirect)
         pc_d = sel_target;
      else if (fetch_acc)
         pc_d = pc_q + step;
   end

   // Control FSM with registered status outputs and the PC register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= PC_ST_BOOT;
         pc_q       <= RST_PC;
         boot_cnt_q <= '0;
         valid_q    <= 1'b0;
         halted_q   <= 1'b0;
         redirect_q <= 1'b0;
         misalign_q <= 1'b0;
      end else begin
         pc_q       <= pc_d;
         redirect_q <= sel_redirect;
         misalign_q <= sel_misalign;
         case (state_q)
            PC_ST_BOOT: begin
               if (boot_done) begin
                  state_q <= PC_ST_RUN;
                  valid_q <= 1'b1;
               end else begin
                  boot_cnt_q <= boot_cnt_q + 8'd1;
               end
            end
            PC_ST_RUN: begin
               if (halt_req_i) begin
                  state_q  <= PC_ST_HALT;
                  valid_q  <= 1'b0;
                  halted_q <= 1'b1;
               end
            end
            PC_ST_HALT: begin
               if (resume_i && !halt_req_i) begin
                  state_q  <= PC_ST_RUN;
                  valid_q  <= 1'b1;
                  halted_q <= 1'b0;
               end
            end
            default: begin
               state_q  <= PC_ST_BOOT;
               valid_q  <= 1'b0;
               halted_q <= 1'b0;
            end
         endcase
      end
   end

   assign fetch_if.pc_addr_o  = pc_q;
   assign fetch_if.pc_valid_o = valid_q;
   assign halted_o            = halted_q;
   assign redirect_o          = redirect_q;
   assign misalign_o          = misalign_q;

endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen: directed scenarios followed by randomized traffic, all checked
// every cycle against a mode/countdown reference model of the PC generator.
module tb_pc_gen;

   localparam int          AW = 32;
   localparam logic [31:0] RA = 32'h0000_0100;
   localparam int          BD = 4;
`ifdef PC_COMPRESSED_EN
   localparam logic [31:0] AMASK = 32'hFFFF_FFFE;
`else
   localparam logic [31:0] AMASK = 32'hFFFF_FFFC;
`endif

   logic        clk = 1'b0;
   logic        rst, stall, jen, ten, hreq, res, rdy, ilen;
   logic [31:0] jaddr, taddr;
   logic        halted, redir, mis;

   pc_gen_if #(.ADDR_WIDTH(AW)) fif ();
   assign fif.fetch_ready_i = rdy;
`ifdef PC_COMPRESSED_EN
   assign fif.inst_len_i = ilen;
`endif

   pc_gen #(
      .ADDR_WIDTH (AW),
      .RESET_ADDR (RA),
      .BOOT_DELAY (BD)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .stall_i     (stall),
      .jump_en_i   (jen),
      .jump_addr_i (jaddr),
      .trap_en_i   (ten),
      .trap_addr_i (taddr),
      .halt_req_i  (hreq),
      .resume_i    (res),
      .fetch_if    (fif),
      .halted_o    (halted),
      .redirect_o  (redir),
      .misalign_o  (mis)
   );

   always #5 clk = ~clk;

   // Reference model: mode 0 = booting, 1 = running, 2 = halted
   int          m_mode;
   int          m_boot_left;
   logic [31:0] m_pc;
   logic        m_red, m_mis;

   int n_total = 0;
   int n_pass  = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
   endtask

   task automatic m_redirect(input logic [31:0] a);
      m_pc  = a & AMASK;
      m_red = 1'b1;
      m_mis = (a & ~AMASK) != 32'h0;
   endtask

   task automatic model_step();
      logic [31:0] inc;
`ifdef PC_COMPRESSED_EN
      inc = ilen ? 32'd4 : 32'd2;
`else
      inc = 32'd4;
`endif
      if (rst) begin
         m_mode      = 0;
         m_pc        = RA;
         m_boot_left = (BD == 0) ? 1 : BD;
         m_red       = 1'b0;
         m_mis       = 1'b0;
      end else if (m_mode == 0) begin
         m_red = 1'b0;
         m_mis = 1'b0;
         m_boot_left--;
         if (m_boot_left == 0) m_mode = 1;
      end else if (m_mode == 1) begin
         if (ten) m_redirect(taddr);
         else if (jen) m_redirect(jaddr);
         else begin
            m_red = 1'b0;
            m_mis = 1'b0;
            if (!stall && rdy) m_pc = m_pc + inc;
         end
         if (hreq) m_mode = 2;
      end else begin
         if (jen) m_redirect(jaddr);
         else begin
            m_red = 1'b0;
            m_mis = 1'b0;
         end
         if (res && !hreq) m_mode = 1;
      end
   endtask

   // Advance one clock and compare every output with the model
   task automatic cycle();
      model_step();
      @(posedge clk);
      #1;
      chk("pc",       fif.pc_addr_o,           m_pc);
      chk("valid",    {31'b0, fif.pc_valid_o}, {31'b0, m_mode == 1});
      chk("halted",   {31'b0, halted},         {31'b0, m_mode == 2});
      chk("redirect", {31'b0, redir},          {31'b0, m_red});
      chk("misalign", {31'b0, mis},            {31'b0, m_mis});
   endtask

   task automatic idle_inputs();
      stall = 0; jen = 0; ten = 0; hreq = 0; res = 0;
   endtask

   initial begin
      rst = 1; rdy = 1; ilen = 1; jaddr = 0; taddr = 0;
      idle_inputs();

      // Reset, boot delay, then sequential fetch
      cycle();
      chk("rst_pc",    fif.pc_addr_o, RA);
      chk("rst_valid", {31'b0, fif.pc_valid_o}, 32'd0);
      rst = 0;
      cycle(); cycle(); cycle();
      chk("boot_valid", {31'b0, fif.pc_valid_o}, 32'd0);
      cycle();
      chk("first_valid", {31'b0, fif.pc_valid_o}, 32'd1);
      chk("first_pc",    fif.pc_addr_o, 32'h100);
      cycle();
      chk("seq_pc1", fif.pc_addr_o, 32'h104);
      cycle();
      chk("seq_pc2", fif.pc_addr_o, 32'h108);

      // Memory back-pressure holds the address
      rdy = 0; jen = 1; jaddr = 32'h200;
      cycle();
      jen = 0;
      cycle(); cycle(); cycle();
      chk("bp_hold", fif.pc_addr_o, 32'h200);
      rdy = 1;
      cycle();
      chk("bp_adv", fif.pc_addr_o, 32'h204);
      rdy = 0;

      // Trap beats jump; misaligned jump target
      ten = 1; taddr = 32'h80; jen = 1; jaddr = 32'h403;
      cycle();
      chk("trap_pc",  fif.pc_addr_o, 32'h80);
      chk("trap_red", {31'b0, redir}, 32'd1);
      chk("trap_mis", {31'b0, mis},   32'd0);
      ten = 0;
      cycle();
      chk("jmp_pc",  fif.pc_addr_o, 32'h403 & AMASK);
      chk("jmp_mis", {31'b0, mis}, 32'd1);
      jen = 0;
      cycle();
      chk("mis_pulse", {31'b0, mis}, 32'd0);

      // Halt with simultaneous jump, debug PC write, ignored trap, resume
      hreq = 1; jen = 1; jaddr = 32'h500;
      cycle();
      chk("halt_pc",  fif.pc_addr_o, 32'h500);
      chk("halt_flg", {31'b0, halted}, 32'd1);
      hreq = 0; jaddr = 32'h600;
      cycle();
      chk("dbg_write", fif.pc_addr_o, 32'h600);
      jen = 0; ten = 1; taddr = 32'h80;
      cycle();
      chk("halt_trap", fif.pc_addr_o, 32'h600);
      ten = 0; res = 1; hreq = 1;
      cycle();
      chk("halt_wins", {31'b0, halted}, 32'd1);
      hreq = 0;
      cycle();
      chk("resume_valid", {31'b0, fif.pc_valid_o}, 32'd1);
      chk("resume_pc",    fif.pc_addr_o, 32'h600);
      res = 0;

      // Wrap-around, then reset overriding a pending jump and halt
      jen = 1; jaddr = 32'hFFFF_FFFC;
      cycle();
      jen = 0; rdy = 1;
      cycle();
      chk("wrap_pc",  fif.pc_addr_o, 32'h0);
      chk("wrap_red", {31'b0, redir}, 32'd0);
      rst = 1; jen = 1; jaddr = 32'h700; hreq = 1;
      cycle();
      chk("mid_rst_pc",    fif.pc_addr_o, RA);
      chk("mid_rst_valid", {31'b0, fif.pc_valid_o}, 32'd0);
      chk("mid_rst_halt",  {31'b0, halted}, 32'd0);
      rst = 0;
      idle_inputs();

      // Randomized traffic
      for (int i = 0; i < 600; i++) begin
         rst   = ($urandom_range(0, 79) == 0);
         stall = ($urandom_range(0, 3) == 0);
         ten   = ($urandom_range(0, 9) == 0);
         jen   = ($urandom_range(0, 5) == 0);
         taddr = $urandom;
         jaddr = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF8 : $urandom;
         hreq  = ($urandom_range(0, 11) == 0);
         res   = ($urandom_range(0, 2) == 0);
         rdy   = ($urandom_range(0, 3) != 0);
         ilen  = $urandom_range(0, 1) == 1;
         cycle();
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
